serial_sub_nbit: RTL
====================

// Module: serial_sub_nbit
// PURPOSE
//  Bit-serial N-bit unsigned subtractor (diff = a - b), the borrow-FSM counterpart of the bit-serial adder.
//  Accepts parallel operands over a valid/ready handshake and processes one bit per clock, LSB first,
//  using a 1-bit borrow state machine. Returns the parallel difference, the final borrow and a zero
//  flag over a second valid/ready handshake. Sits between a parallel producer and consumer in the
//  arithmetic datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range WIDTH >= 2
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operands a,b valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  minuend, unsigned
//  b          in   WIDTH  subtrahend, unsigned
//  out_valid  out  1      result valid (high only in DONE)
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  (a - b) mod 2^WIDTH
//  borrow     out  1      final borrow out; 1 iff a < b
//  zero       out  1      1 iff diff == 0
// BEHAVIOUR
//  Reset: on any edge with rst=1 -> state IDLE, shift regs/counter/borrow state cleared;
//   diff=0, borrow=0, zero=0, out_valid=0, in_ready=1 from the following cycle. rst overrides all
//   inputs and aborts any operation in progress; no partial result is ever presented.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: in_ready=1. On edge with in_valid=1: latch a->a_sr, b->b_sr, borrow state B0 (no borrow),
//    bit counter=0 -> RUN. Otherwise stay.
//   RUN: in_ready=0, out_valid=0. Each cycle with a0=a_sr[0], b0=b_sr[0], bs=borrow state:
//    d = a0 ^ b0 ^ bs;  next bs = (~a0 & b0) | (~(a0 ^ b0) & bs).
//    Borrow FSM: B0->B1 on (a0,b0)=(0,1); B1->B0 on (1,0); otherwise hold.
//    d shifts into the result register MSB end (result shifts right); a_sr, b_sr shift right; counter++.
//    At the edge where counter == WIDTH-1 (the WIDTH-th bit): capture the full result into diff,
//    the final bs into borrow, and (result == 0) into zero -> DONE.
//    in_valid is ignored in RUN; a,b need not be held after acceptance.
//   DONE: out_valid=1; diff/borrow/zero stable while out_ready=0 (no limit on stall length).
//    On edge with out_ready=1 -> IDLE. No IDLE bypass: a new operand is accepted no earlier than
//    the cycle after the result handshake.
//  Latency: out_valid rises exactly WIDTH cycles after the input-accept edge.
//   Minimum issue interval WIDTH+2 cycles (WIDTH RUN + 1 DONE + 1 IDLE) with out_ready tied high.
//  Outputs are registered; diff/borrow/zero keep the last result after the output handshake until
//   the next DONE entry or reset. out_valid/in_ready decode from the state register only.
//  Width rules: the counter is $clog2(WIDTH) bits. All arithmetic is unsigned modulo 2^WIDTH, and
//   the wrap on underflow is reported only via borrow.
//  Illegal state encodings recover to IDLE.
// TESTING (WIDTH=8)
//  1. a=0x5A, b=0x33, out_ready=1 -> out_valid 8 cycles after accept; diff=0x27, borrow=0, zero=0.
//  2. a=0x10, b=0x20 -> diff=0xF0, borrow=1, zero=0; a=0x00, b=0x01 -> diff=0xFF, borrow=1.
//  3. a=0xFF, b=0xFF -> diff=0x00, borrow=0, zero=1; a=0x80, b=0x00 -> diff=0x80, borrow=0.
//  4. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, diff, borrow, zero held and
//     in_ready=0 throughout; raising out_ready -> IDLE next cycle, in_ready=1.
//  5. rst=1 at RUN bit 4, with in_valid toggling -> next cycle IDLE, all outputs 0, in_ready=1;
//     a new op 0x5A-0x33 then completes correctly.
//  6. Back-to-back ops, in_valid and out_ready held high, plus in_valid pulsed during RUN ->
//     accepts spaced exactly 10 cycles apart, RUN-time inputs ignored; random 1000-op check vs a-b.

Source files
------------

// File: rtl/serial_sub_nbit.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
// A valid/ready handshake on each side; a 1-bit borrow state carries between bit slices.
//
//  state  | meaning
//  -------+----------------------------------------------------------
//  IDLE   | waiting for operands, in_ready=1
//  RUN    | shifting one bit per cycle through the borrow slice
//  DONE   | result presented, out_valid=1 until out_ready
module serial_sub_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic [CNT_W-1:0]   bit_cnt;
    logic               bs;

    logic               a0;
    logic               b0;
    logic               d_bit;
    logic               bs_nxt;
    logic               last_bit;
    logic [WIDTH-1:0]   res_nxt;

    // one full-subtractor slice on the current LSBs
    always_comb begin
        a0       = a_sr[0];
        b0       = b_sr[0];
        d_bit    = a0 ^ b0 ^ bs;
        bs_nxt   = (~a0 & b0) | (~(a0 ^ b0) & bs);
        res_nxt  = {d_bit, res_sr[WIDTH-1:1]};
        last_bit = (bit_cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE: state_nxt = in_valid ? S_RUN : S_IDLE;
            S_RUN:  state_nxt = last_bit ? S_DONE : S_RUN;
            S_DONE: state_nxt = out_ready ? S_IDLE : S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            bit_cnt <= '0;
            bs      <= 1'b0;
            diff    <= '0;
            borrow  <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        res_sr  <= '0;
                        bit_cnt <= '0;
                        bs      <= 1'b0;
                    end
                end
                S_RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    res_sr  <= res_nxt;
                    bs      <= bs_nxt;
                    bit_cnt <= bit_cnt + 1'b1;
                    // last slice: publish the completed word, not the pre-shift register
                    if (last_bit) begin
                        diff   <= res_nxt;
                        borrow <= bs_nxt;
                        zero   <= (res_nxt == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
